// File: rtl/wb_writeback_unit.sv
// Registered write-back stage: selects ALU/load/PC+4/CSR data, extends loads,
// flags misaligned loads and drives the register-file write port and retire counter.
module wb_writeback_unit #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned RETIRE_WIDTH   = 32,
    localparam int unsigned OFF_W         = $clog2(WORD_SIZE / 8)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      wb_stall,
    input  logic                      wb_flush,
    input  logic [WORD_SIZE-1:0]      alu_data,
    input  logic [WORD_SIZE-1:0]      mem_data,
    input  logic [WORD_SIZE-1:0]      pc_plus4,
    input  logic [WORD_SIZE-1:0]      csr_data,
    input  logic [1:0]                wb_sel,
    input  logic [2:0]                load_funct3,
    input  logic [OFF_W-1:0]          byte_offset,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      reg_write,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [WORD_SIZE-1:0]      rf_wdata,
    output logic                      load_misalign,
    output logic [RETIRE_WIDTH-1:0]   retire_count
);

    logic                      r_valid;
    logic                      r_rf_we;
    logic [REG_ADDR_WIDTH-1:0] r_waddr;
    logic [WORD_SIZE-1:0]      r_wdata;
    logic                      r_misalign;
    logic [RETIRE_WIDTH-1:0]   r_retire_count;

    logic [WORD_SIZE-1:0]      w_shifted;
    logic [WORD_SIZE-1:0]      w_load_data;
    logic [WORD_SIZE-1:0]      w_sel_data;
    logic                      w_misalign;
    logic                      w_rf_we_d;
    logic                      w_misalign_d;

    assign in_ready = ~wb_stall;

    // Byte offset selects the addressed bytes; memory word arrives naturally aligned.
    assign w_shifted = mem_data >> {byte_offset, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        unique case (load_funct3)
            3'b000:  w_load_data = WORD_SIZE'($signed(w_shifted[7:0]));
            3'b100:  w_load_data = WORD_SIZE'(w_shifted[7:0]);
            3'b001:  w_load_data = WORD_SIZE'($signed(w_shifted[15:0]));
            3'b101:  w_load_data = WORD_SIZE'(w_shifted[15:0]);
            3'b010:  w_load_data = WORD_SIZE'($signed(w_shifted[31:0]));
            3'b110:  w_load_data = WORD_SIZE'(w_shifted[31:0]);
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_misalign = 1'b0;
        if (wb_sel == 2'b01) begin
            unique case (load_funct3[1:0])
                2'b00:   w_misalign = 1'b0;
                2'b01:   w_misalign = byte_offset[0];
                2'b10:   w_misalign = (byte_offset[1:0] != 2'b00);
                default: w_misalign = (byte_offset != '0);
            endcase
        end
    end

    always_comb begin
        w_sel_data = alu_data;
        unique case (wb_sel)
            2'b00:   w_sel_data = alu_data;
            2'b01:   w_sel_data = w_load_data;
            2'b10:   w_sel_data = pc_plus4;
            default: w_sel_data = csr_data;
        endcase
    end

    assign w_rf_we_d    = in_valid & reg_write & (rd_addr != '0) & ~w_misalign;
    assign w_misalign_d = in_valid & w_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rf_we    <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_misalign <= 1'b0;
        end else if (wb_flush) begin
            r_valid    <= 1'b0;
            r_rf_we    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (!wb_stall) begin
            r_valid    <= in_valid;
            r_rf_we    <= w_rf_we_d;
            r_waddr    <= rd_addr;
            r_wdata    <= w_sel_data;
            r_misalign <= w_misalign_d;
        end
    end

    // The instruction in WB retires when it leaves the stage, even if a flush kills its successor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_count <= '0;
        end else if (r_valid && !wb_stall) begin
            r_retire_count <= r_retire_count + RETIRE_WIDTH'(1);
        end
    end

    assign rf_we         = r_rf_we;
    assign rf_waddr      = r_waddr;
    assign rf_wdata      = r_wdata;
    assign load_misalign = r_misalign;
    assign retire_count  = r_retire_count;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit; a second instance with a 4-bit counter checks wrap-around.
module tb_wb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        wb_stall;
    logic        wb_flush;
    logic [31:0] alu_data;
    logic [31:0] mem_data;
    logic [31:0] pc_plus4;
    logic [31:0] csr_data;
    logic [1:0]  wb_sel;
    logic [2:0]  load_funct3;
    logic [1:0]  byte_offset;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        load_misalign;
    logic [31:0] retire_count;

    logic        s_in_ready;
    logic        s_rf_we;
    logic [4:0]  s_rf_waddr;
    logic [31:0] s_rf_wdata;
    logic        s_load_misalign;
    logic [3:0]  s_retire_count;

    int checks;
    int failures;

    wb_writeback_unit #(
        .WORD_SIZE      (32),
        .REG_ADDR_WIDTH (5),
        .RETIRE_WIDTH   (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wb_stall      (wb_stall),
        .wb_flush      (wb_flush),
        .alu_data      (alu_data),
        .mem_data      (mem_data),
        .pc_plus4      (pc_plus4),
        .csr_data      (csr_data),
        .wb_sel        (wb_sel),
        .load_funct3   (load_funct3),
        .byte_offset   (byte_offset),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .load_misalign (load_misalign),
        .retire_count  (retire_count)
    );

    wb_writeback_unit #(
        .WORD_SIZE      (32),
        .REG_ADDR_WIDTH (5),
        .RETIRE_WIDTH   (4)
    ) dut_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (s_in_ready),
        .wb_stall      (wb_stall),
        .wb_flush      (wb_flush),
        .alu_data      (alu_data),
        .mem_data      (mem_data),
        .pc_plus4      (pc_plus4),
        .csr_data      (csr_data),
        .wb_sel        (wb_sel),
        .load_funct3   (load_funct3),
        .byte_offset   (byte_offset),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .rf_we         (s_rf_we),
        .rf_waddr      (s_rf_waddr),
        .rf_wdata      (s_rf_wdata),
        .load_misalign (s_load_misalign),
        .retire_count  (s_retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] off, input logic [4:0] rd, input logic we);
        in_valid    = v;
        wb_sel      = sel;
        load_funct3 = f3;
        byte_offset = off;
        rd_addr     = rd;
        reg_write   = we;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wb_stall = 1'b0;
        wb_flush = 1'b0;
        alu_data = '0;
        mem_data = '0;
        pc_plus4 = '0;
        csr_data = '0;
        drive(1'b0, 2'b00, 3'b000, 2'd0, 5'd0, 1'b0);

        step();
        step();
        check("rst_rf_we", {31'b0, rf_we}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_waddr", {27'b0, rf_waddr}, 32'd0);
        check("rst_misalign", {31'b0, load_misalign}, 32'd0);
        check("rst_count", retire_count, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // ALU write to x5
        alu_data = 32'h0000_1234;
        drive(1'b1, 2'b00, 3'b000, 2'd0, 5'd5, 1'b1);
        step();
        check("alu_we", {31'b0, rf_we}, 32'd1);
        check("alu_waddr", {27'b0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'h0000_1234);
        check("alu_count_latency", retire_count, 32'd0);
        in_valid = 1'b0;
        step();
        check("idle_we", {31'b0, rf_we}, 32'd0);
        check("alu_count", retire_count, 32'd1);

        // LB / LBU at offset 3
        mem_data = 32'h80FF_7F01;
        drive(1'b1, 2'b01, 3'b000, 2'd3, 5'd6, 1'b1);
        step();
        check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        check("lb_we", {31'b0, rf_we}, 32'd1);
        drive(1'b1, 2'b01, 3'b100, 2'd3, 5'd6, 1'b1);
        step();
        check("lbu_wdata", rf_wdata, 32'h0000_0080);
        check("lbu_count", retire_count, 32'd2);

        // Misaligned LH at offset 1
        drive(1'b1, 2'b01, 3'b001, 2'd1, 5'd7, 1'b1);
        step();
        check("lh_mis_we", {31'b0, rf_we}, 32'd0);
        check("lh_mis_flag", {31'b0, load_misalign}, 32'd1);
        check("lh_mis_count", retire_count, 32'd3);

        // Aligned LHU at offset 2 clears the pulse
        drive(1'b1, 2'b01, 3'b101, 2'd2, 5'd7, 1'b1);
        step();
        check("lhu_flag", {31'b0, load_misalign}, 32'd0);
        check("lhu_wdata", rf_wdata, 32'h0000_80FF);
        check("lhu_we", {31'b0, rf_we}, 32'd1);
        check("lh_mis_retired", retire_count, 32'd4);

        // Misaligned LW at offset 2
        drive(1'b1, 2'b01, 3'b010, 2'd2, 5'd8, 1'b1);
        step();
        check("lw_mis_flag", {31'b0, load_misalign}, 32'd1);
        check("lw_mis_we", {31'b0, rf_we}, 32'd0);

        // Write to x0 is suppressed
        alu_data = 32'hDEAD_BEEF;
        drive(1'b1, 2'b00, 3'b000, 2'd0, 5'd0, 1'b1);
        step();
        check("x0_we", {31'b0, rf_we}, 32'd0);
        check("x0_count", retire_count, 32'd6);

        // PC+4 link to x9
        pc_plus4 = 32'h0000_0104;
        drive(1'b1, 2'b10, 3'b000, 2'd0, 5'd9, 1'b1);
        step();
        check("pc4_wdata", rf_wdata, 32'h0000_0104);
        check("pc4_waddr", {27'b0, rf_waddr}, 32'd9);
        check("x0_retired", retire_count, 32'd7);

        // Stall three cycles with a new instruction waiting
        alu_data = 32'h0000_0055;
        drive(1'b1, 2'b00, 3'b000, 2'd0, 5'd10, 1'b1);
        wb_stall = 1'b1;
        #1;
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_wdata", rf_wdata, 32'h0000_0104);
            check("stall_we", {31'b0, rf_we}, 32'd1);
            check("stall_count", retire_count, 32'd7);
        end
        wb_stall = 1'b0;
        step();
        check("unstall_wdata", rf_wdata, 32'h0000_0055);
        check("unstall_waddr", {27'b0, rf_waddr}, 32'd10);
        check("unstall_count", retire_count, 32'd8);

        // Flush kills the instruction being captured
        wb_flush = 1'b1;
        step();
        check("flush_we", {31'b0, rf_we}, 32'd0);
        check("flush_count", retire_count, 32'd9);
        wb_flush = 1'b0;

        // CSR write, then async reset mid-cycle
        csr_data = 32'h0000_0ABC;
        drive(1'b1, 2'b11, 3'b000, 2'd0, 5'd11, 1'b1);
        step();
        check("csr_wdata", rf_wdata, 32'h0000_0ABC);
        check("csr_we", {31'b0, rf_we}, 32'd1);
        check("flush_not_retired", retire_count, 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'b0, rf_we}, 32'd0);
        check("arst_wdata", rf_wdata, 32'd0);
        check("arst_count", retire_count, 32'd0);
        check("arst_small_count", {28'b0, s_retire_count}, 32'd0);
        step();
        rst_n = 1'b1;

        // Counter wrap on the 4-bit instance
        alu_data = 32'h0000_0001;
        drive(1'b1, 2'b00, 3'b000, 2'd0, 5'd1, 1'b1);
        for (int i = 0; i < 16; i++) step();
        check("wrap_pre_small", {28'b0, s_retire_count}, 32'h0000_000F);
        check("wrap_pre_main", retire_count, 32'd15);
        step();
        check("wrap_small", {28'b0, s_retire_count}, 32'd0);
        check("wrap_main", retire_count, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
